// File: rtl/game_pkg.sv
// Shared constants for the guess-entry producer and the game display:
// key codes, entry-FSM state encoding and the BCD digit width.
package game_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [3:0] KEY_BKSP  = 4'hA;
   localparam logic [3:0] KEY_ENTER = 4'hB;
   localparam logic [3:0] KEY_CLR   = 4'hC;

   localparam logic [1:0] ST_EMPTY   = 2'd0;
   localparam logic [1:0] ST_PARTIAL = 2'd1;
   localparam logic [1:0] ST_FULL    = 2'd2;
   localparam logic [1:0] ST_EMIT    = 2'd3;

   function automatic logic has_dup(input logic [DIGIT_W-1:0] a,
                                    input logic [DIGIT_W-1:0] b,
                                    input logic [DIGIT_W-1:0] c);
      return (a == b) || (a == c) || (b == c);
   endfunction

endpackage

// File: rtl/guess_entry_idle_timer.sv
// Idle timer: counts cycles while enabled and not restarted; expire is a
// combinational pulse at TIMEOUT_CYCLES-1. TIMEOUT_CYCLES==0 disables it.
module idle_timer #(
   parameter int TIMEOUT_CYCLES = 50_000_000,
   parameter int CNT_W          = 26
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   input  logic enable,
   output logic expire
);

   localparam logic [CNT_W-1:0] LP_LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
   localparam bit LP_ON = (TIMEOUT_CYCLES != 0);

   logic [CNT_W-1:0] r_cnt;
   logic             w_at_last;

   assign w_at_last = (r_cnt == LP_LAST);
   assign expire    = LP_ON && enable && !restart && w_at_last;

   always_ff @(posedge clk) begin
      if (reset || restart || !enable || !LP_ON || w_at_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/guess_entry.sv
// Three-digit guess entry from a key-event stream with backspace/clear/enter.
// Build option: GUESS_DUP_CHECK_EN rejects an enter whose three digits are not distinct.
//
// state      | meaning
// EMPTY      | no digits entered
// PARTIAL    | one or two digits entered
// FULL       | three digits entered, awaiting enter
// EMIT       | one cycle: guess presented with oNumRdy, keys ignored
module guess_entry
   import game_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50_000_000,
   parameter int CNT_W          = 26
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               iKeyVld,
   input  logic [3:0]         iKeyCode,
   output logic [DIGIT_W-1:0] oNum1,
   output logic [DIGIT_W-1:0] oNum2,
   output logic [DIGIT_W-1:0] oNum3,
   output logic               oNumRdy,
   output logic [DIGIT_W-1:0] oEntry1,
   output logic [DIGIT_W-1:0] oEntry2,
   output logic [DIGIT_W-1:0] oEntry3,
   output logic [1:0]         oCount,
   output logic               oErr,
   output logic               oTimeout
);

   logic [1:0]         r_state;
   logic [1:0]         r_count;
   logic [DIGIT_W-1:0] r_e1, r_e2, r_e3;
   logic [DIGIT_W-1:0] r_n1, r_n2, r_n3;
   logic               r_err, r_rdy, r_tout;
   logic               w_expire;
   logic               w_is_digit;

   assign w_is_digit = (iKeyCode <= 4'd9);

   idle_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .CNT_W         (CNT_W)
   ) u_idle_timer (
      .clk    (clk),
      .reset  (reset),
      .restart(iKeyVld),
      .enable (r_count != 2'd0),
      .expire (w_expire)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_EMPTY;
         r_count <= 2'd0;
         r_e1    <= '0;
         r_e2    <= '0;
         r_e3    <= '0;
         r_n1    <= '0;
         r_n2    <= '0;
         r_n3    <= '0;
         r_err   <= 1'b0;
         r_rdy   <= 1'b0;
         r_tout  <= 1'b0;
      end else begin
         r_err  <= 1'b0;
         r_rdy  <= 1'b0;
         r_tout <= 1'b0;
         if (r_state == ST_EMIT) begin
            r_state <= ST_EMPTY;
         end else if (iKeyVld) begin
            if (w_is_digit) begin
               case (r_count)
                  2'd0: begin r_e1 <= iKeyCode; r_count <= 2'd1; r_state <= ST_PARTIAL; end
                  2'd1: begin r_e2 <= iKeyCode; r_count <= 2'd2; r_state <= ST_PARTIAL; end
                  2'd2: begin r_e3 <= iKeyCode; r_count <= 2'd3; r_state <= ST_FULL;    end
                  default: r_err <= 1'b1;
               endcase
            end else begin
               case (iKeyCode)
                  KEY_BKSP: begin
                     case (r_count)
                        2'd1: begin r_e1 <= '0; r_count <= 2'd0; r_state <= ST_EMPTY;   end
                        2'd2: begin r_e2 <= '0; r_count <= 2'd1; r_state <= ST_PARTIAL; end
                        2'd3: begin r_e3 <= '0; r_count <= 2'd2; r_state <= ST_PARTIAL; end
                        default: ;
                     endcase
                  end
                  KEY_CLR: begin
                     r_e1    <= '0;
                     r_e2    <= '0;
                     r_e3    <= '0;
                     r_count <= 2'd0;
                     r_state <= ST_EMPTY;
                  end
                  KEY_ENTER: begin
                     if (r_count != 2'd3) begin
                        r_err <= 1'b1;
`ifdef GUESS_DUP_CHECK_EN
                     end else if (has_dup(r_e1, r_e2, r_e3)) begin
                        r_err <= 1'b1;
`endif
                     end else begin
                        // Guess goes out on the same edge the entry is wiped.
                        r_n1    <= r_e1;
                        r_n2    <= r_e2;
                        r_n3    <= r_e3;
                        r_rdy   <= 1'b1;
                        r_e1    <= '0;
                        r_e2    <= '0;
                        r_e3    <= '0;
                        r_count <= 2'd0;
                        r_state <= ST_EMIT;
                     end
                  end
                  default: ;
               endcase
            end
         end else if (w_expire) begin
            r_e1    <= '0;
            r_e2    <= '0;
            r_e3    <= '0;
            r_count <= 2'd0;
            r_state <= ST_EMPTY;
            r_tout  <= 1'b1;
         end
      end
   end

   assign oNum1    = r_n1;
   assign oNum2    = r_n2;
   assign oNum3    = r_n3;
   assign oNumRdy  = r_rdy;
   assign oEntry1  = r_e1;
   assign oEntry2  = r_e2;
   assign oEntry3  = r_e3;
   assign oCount   = r_count;
   assign oErr     = r_err;
   assign oTimeout = r_tout;

endmodule

// File: tb/tb_guess_entry.sv
// Bench for guess_entry: directed table, multi-cycle corner sequences and
// random key streams checked against a queue-based reference model.
module tb_guess_entry;

   localparam int TO = 16;
`ifdef GUESS_DUP_CHECK_EN
   localparam bit DUP_EN = 1'b1;
`else
   localparam bit DUP_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       iKeyVld = 1'b0;
   logic [3:0] iKeyCode = 4'h0;
   logic [3:0] oNum1, oNum2, oNum3, oEntry1, oEntry2, oEntry3;
   logic       oNumRdy, oErr, oTimeout;
   logic [1:0] oCount;

   always #5 clk = ~clk;

   guess_entry #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .iKeyVld(iKeyVld), .iKeyCode(iKeyCode),
      .oNum1(oNum1), .oNum2(oNum2), .oNum3(oNum3), .oNumRdy(oNumRdy),
      .oEntry1(oEntry1), .oEntry2(oEntry2), .oEntry3(oEntry3),
      .oCount(oCount), .oErr(oErr), .oTimeout(oTimeout)
   );

   int n_chk = 0;
   int n_fail = 0;

   // reference model: the entry is a queue of digits, idle is "cycles without a key"
   int q[$];
   int m_num[3] = '{0, 0, 0};
   bit m_busy = 1'b0;
   int m_idle = 0;
   bit m_err, m_rdy, m_tout;

   task automatic model_step(input bit rst, input bit vld, input logic [3:0] code);
      m_err = 1'b0; m_rdy = 1'b0; m_tout = 1'b0;
      if (rst) begin
         q.delete(); m_num = '{0, 0, 0}; m_busy = 1'b0; m_idle = 0;
      end else if (m_busy) begin
         m_busy = 1'b0; m_idle = 0;
      end else if (vld) begin
         m_idle = 0;
         if (code <= 4'd9) begin
            if (q.size() == 3) m_err = 1'b1;
            else q.push_back(int'(code));
         end else if (code == 4'hA) begin
            if (q.size() > 0) void'(q.pop_back());
         end else if (code == 4'hC) begin
            q.delete();
         end else if (code == 4'hB) begin
            if (q.size() != 3) m_err = 1'b1;
            else if (DUP_EN && (q[0] == q[1] || q[0] == q[2] || q[1] == q[2])) m_err = 1'b1;
            else begin
               m_num = '{q[0], q[1], q[2]};
               q.delete(); m_rdy = 1'b1; m_busy = 1'b1;
            end
         end
      end else if (q.size() == 0) begin
         m_idle = 0;
      end else begin
         m_idle++;
         if (m_idle == TO) begin
            q.delete(); m_tout = 1'b1; m_idle = 0;
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_ent();
      int e[3] = '{0, 0, 0};
      for (int i = 0; i < q.size(); i++) e[i] = q[i];
      return (e[0] << 8) | (e[1] << 4) | e[2];
   endfunction

   task automatic check_model();
      chk("model_num",   int'({oNum1, oNum2, oNum3}), (m_num[0] << 8) | (m_num[1] << 4) | m_num[2]);
      chk("model_entry", int'({oEntry1, oEntry2, oEntry3}), m_ent());
      chk("model_count", int'(oCount), q.size());
      chk("model_pulses", int'({oErr, oNumRdy, oTimeout}), int'({m_err, m_rdy, m_tout}));
   endtask

   task automatic step(input bit rst, input bit vld, input logic [3:0] code);
      reset = rst; iKeyVld = vld; iKeyCode = code;
      @(posedge clk);
      model_step(rst, vld, code);
      #1;
      check_model();
      reset = 1'b0; iKeyVld = 1'b0;
   endtask

   task automatic key(input logic [3:0] code);
      step(1'b0, 1'b1, code);
      step(1'b0, 1'b0, 4'h0);
   endtask

   typedef struct {
      bit         rst;
      bit         vld;
      logic [3:0] code;
      int         cnt;
      int         ent;
      bit         err;
      bit         rdy;
      int         num;
   } vec_t;
   vec_t tbl[$];

   function automatic void row(input bit rst, input bit vld, input logic [3:0] code,
                               input int cnt, input int ent, input bit err,
                               input bit rdy, input int num);
      vec_t v;
      v.rst = rst; v.vld = vld; v.code = code; v.cnt = cnt; v.ent = ent;
      v.err = err; v.rdy = rdy; v.num = num;
      tbl.push_back(v);
   endfunction

   initial begin
      int gap;
      int r;
      logic [3:0] c;

      row(1, 0, 4'h0, 0, 'h000, 0, 0, 'h000);
      row(0, 1, 4'h1, 1, 'h100, 0, 0, 'h000);  row(0, 0, 4'h0, 1, 'h100, 0, 0, 'h000);
      row(0, 1, 4'h2, 2, 'h120, 0, 0, 'h000);  row(0, 0, 4'h0, 2, 'h120, 0, 0, 'h000);
      row(0, 1, 4'h3, 3, 'h123, 0, 0, 'h000);  row(0, 0, 4'h0, 3, 'h123, 0, 0, 'h000);
      row(0, 1, 4'hB, 0, 'h000, 0, 1, 'h123);  row(0, 0, 4'h0, 0, 'h000, 0, 0, 'h123);
      row(0, 1, 4'h4, 1, 'h400, 0, 0, 'h123);  row(0, 0, 4'h0, 1, 'h400, 0, 0, 'h123);
      row(0, 1, 4'h5, 2, 'h450, 0, 0, 'h123);  row(0, 0, 4'h0, 2, 'h450, 0, 0, 'h123);
      row(0, 1, 4'hA, 1, 'h400, 0, 0, 'h123);  row(0, 0, 4'h0, 1, 'h400, 0, 0, 'h123);
      row(0, 1, 4'h6, 2, 'h460, 0, 0, 'h123);  row(0, 0, 4'h0, 2, 'h460, 0, 0, 'h123);
      row(0, 1, 4'h7, 3, 'h467, 0, 0, 'h123);  row(0, 0, 4'h0, 3, 'h467, 0, 0, 'h123);
      row(0, 1, 4'hB, 0, 'h000, 0, 1, 'h467);  row(0, 0, 4'h0, 0, 'h000, 0, 0, 'h467);
      row(0, 1, 4'hA, 0, 'h000, 0, 0, 'h467);  row(0, 0, 4'h0, 0, 'h000, 0, 0, 'h467);
      row(0, 1, 4'h8, 1, 'h800, 0, 0, 'h467);  row(0, 0, 4'h0, 1, 'h800, 0, 0, 'h467);
      row(0, 1, 4'hB, 1, 'h800, 1, 0, 'h467);  row(0, 0, 4'h0, 1, 'h800, 0, 0, 'h467);
      row(0, 1, 4'h9, 2, 'h890, 0, 0, 'h467);  row(0, 0, 4'h0, 2, 'h890, 0, 0, 'h467);
      row(0, 1, 4'h1, 3, 'h891, 0, 0, 'h467);  row(0, 0, 4'h0, 3, 'h891, 0, 0, 'h467);
      row(0, 1, 4'h2, 3, 'h891, 1, 0, 'h467);  row(0, 0, 4'h0, 3, 'h891, 0, 0, 'h467);
      row(0, 1, 4'hE, 3, 'h891, 0, 0, 'h467);  row(0, 0, 4'h0, 3, 'h891, 0, 0, 'h467);
      row(0, 1, 4'hC, 0, 'h000, 0, 0, 'h467);  row(0, 0, 4'h0, 0, 'h000, 0, 0, 'h467);

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].vld, tbl[i].code);
         chk("tbl_count", int'(oCount), tbl[i].cnt);
         chk("tbl_entry", int'({oEntry1, oEntry2, oEntry3}), tbl[i].ent);
         chk("tbl_err",   int'(oErr), int'(tbl[i].err));
         chk("tbl_rdy",   int'(oNumRdy), int'(tbl[i].rdy));
         chk("tbl_num",   int'({oNum1, oNum2, oNum3}), tbl[i].num);
      end

      // key arriving in the EMIT cycle is dropped silently
      key(4'h5); key(4'h6); key(4'h7);
      step(0, 1, 4'hB);
      chk("emit_rdy", int'(oNumRdy), 1);
      step(0, 1, 4'h9);
      chk("emit_ign_err", int'(oErr), 0);
      chk("emit_ign_cnt", int'(oCount), 0);
      step(0, 0, 4'h0);

      // duplicate digits
      key(4'h3); key(4'h3); key(4'h5);
      step(0, 1, 4'hB);
      if (DUP_EN) begin
         chk("dup_err", int'(oErr), 1);
         chk("dup_cnt", int'(oCount), 3);
      end else begin
         chk("dup_rdy", int'(oNumRdy), 1);
         chk("dup_num", int'({oNum1, oNum2, oNum3}), 'h335);
      end
      step(0, 0, 4'h0);
      key(4'hC);

      // idle timeout after 16 idle cycles
      step(0, 1, 4'h5);
      for (int i = 0; i < TO - 1; i++) step(0, 0, 4'h0);
      chk("to_pre_tout", int'(oTimeout), 0);
      chk("to_pre_cnt", int'(oCount), 1);
      step(0, 0, 4'h0);
      chk("to_tout", int'(oTimeout), 1);
      chk("to_cnt", int'(oCount), 0);
      chk("to_entry", int'({oEntry1, oEntry2, oEntry3}), 0);
      step(0, 0, 4'h0);
      chk("to_tout_gone", int'(oTimeout), 0);

      // key on the expiry cycle wins; timer restarts from that key
      step(0, 1, 4'h5);
      for (int i = 0; i < TO - 1; i++) step(0, 0, 4'h0);
      step(0, 1, 4'hD);
      chk("col_tout", int'(oTimeout), 0);
      chk("col_cnt", int'(oCount), 1);
      for (int i = 0; i < TO - 1; i++) step(0, 0, 4'h0);
      chk("col_pre_cnt", int'(oCount), 1);
      step(0, 0, 4'h0);
      chk("col_tout2", int'(oTimeout), 1);

      // reset mid-entry with a key in the same cycle
      key(4'h1); key(4'h2);
      chk("rst_pre_cnt", int'(oCount), 2);
      step(1, 1, 4'h3);
      chk("rst_all", int'({oNum1, oNum2, oNum3, oEntry1, oEntry2, oEntry3, oCount,
                           oErr, oNumRdy, oTimeout}), 0);
      step(0, 0, 4'h0);
      chk("rst_after", int'({oErr, oNumRdy, oTimeout, oCount}), 0);

      // random key streams
      gap = 0;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            step(1, $urandom_range(0, 1) == 1, 4'(($urandom_range(0, 15))));
            continue;
         end
         if (gap > 0) begin
            gap--;
            step(0, 0, 4'h0);
            continue;
         end
         r = $urandom_range(0, 19);
         if (r < 11)       c = 4'($urandom_range(0, 9));
         else if (r < 15)  c = 4'hB;
         else if (r < 17)  c = 4'hA;
         else if (r == 17) c = 4'hC;
         else              c = 4'($urandom_range(13, 15));
         step(0, 1, c);
         gap = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 24) : $urandom_range(0, 2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
